alu_multicycle: RTL and testbench

//   Parametrised execute-stage ALU with registered outputs, a valid/ready handshake and a persistent flag register.

---
 rtl/alu_pkg.sv | 18 +
 rtl/mul_shift_add.sv | 60 ++++++
 rtl/alu_multicycle.sv | 162 ++++++++++++++++
 tb/tb_alu_multicycle.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared op-code and FSM state definitions for the multi-cycle execute ALU.
package alu_pkg;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_NOT = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_SUB = 3'b011;
    localparam logic [2:0] OP_OR  = 3'b100;
    localparam logic [2:0] OP_SHL = 3'b101;
    localparam logic [2:0] OP_SHR = 3'b110;
    localparam logic [2:0] OP_MUL = 3'b111;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

endpackage

// File: rtl/mul_shift_add.sv
// Iterative unsigned shift-add multiplier: one multiplier bit per cycle, W cycles per product.
// done/prod are combinational so the caller can capture the finished product on the final step edge.
module mul_shift_add #(
    parameter int unsigned W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             clear,
    input  logic [W-1:0]     a,
    input  logic [W-1:0]     b,
    output logic             done,
    output logic [2*W-1:0]   prod
);

    localparam int unsigned PW = 2 * W;
    localparam int unsigned CW = $clog2(W);

    logic          r_run;
    logic [CW-1:0] r_cnt;
    logic [PW-1:0] r_acc;
    logic [PW-1:0] r_mcand;
    logic [W-1:0]  r_mplier;
    logic [PW-1:0] w_addend;
    logic [PW-1:0] w_acc_nx;

    assign w_addend = r_mplier[0] ? r_mcand : '0;
    assign w_acc_nx = r_acc + w_addend;
    assign done     = r_run & (r_cnt == '0);
    assign prod     = w_acc_nx;

    // Operand latch on start, one shift-add step per cycle while running, abort on clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_run    <= 1'b0;
            r_cnt    <= '0;
            r_acc    <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
        end else if (clear) begin
            r_run <= 1'b0;
            r_cnt <= '0;
        end else if (start) begin
            r_run    <= 1'b1;
            r_cnt    <= CW'(W - 1);
            r_acc    <= '0;
            r_mcand  <= PW'(a);
            r_mplier <= b;
        end else if (r_run) begin
            r_acc    <= w_acc_nx;
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
            r_cnt    <= r_cnt - CW'(1);
            if (r_cnt == '0) begin
                r_run <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/alu_multicycle.sv
// Execute-stage ALU: single-cycle ADD/SUB/logic/shift, iterative MUL, registered result and flags.
module alu_multicycle
    import alu_pkg::*;
#(
    parameter int unsigned W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         flush,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [2:0]   op,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         out_valid,
    output logic [W-1:0] result,
    output logic         carry,
    output logic         zero,
    output logic         neg
);

    localparam int unsigned SHW = $clog2(W);

    state_t         r_state;
    state_t         w_state_nx;
    logic           r_in_ready;
    logic           r_out_valid;
    logic [W-1:0]   r_result;
    logic           r_carry;
    logic           r_zero;
    logic           r_neg;

    logic [SHW-1:0] w_shamt;
    logic [W:0]     w_add;
    logic [W:0]     w_shl;
    logic [W:0]     w_shr;
    logic [W-1:0]   w_alu_res;
    logic           w_alu_carry;

    logic           w_load;
    logic [W-1:0]   w_res_nx;
    logic           w_carry_nx;
    logic           w_mul_start;
    logic           w_mul_clear;
    logic           w_mul_done;
    logic [2*W-1:0] w_mul_prod;

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign result    = r_result;
    assign carry     = r_carry;
    assign zero      = r_zero;
    assign neg       = r_neg;

    // Widened forms expose the carry-out / last shifted-out bit in the extra position
    assign w_shamt = b[SHW-1:0];
    assign w_add   = {1'b0, a} + {1'b0, b};
    assign w_shl   = {1'b0, a} << w_shamt;
    assign w_shr   = {a, 1'b0} >> w_shamt;

    mul_shift_add #(.W(W)) u_mul (
        .clk   (clk),
        .rst_n (rst_n),
        .start (w_mul_start),
        .clear (w_mul_clear),
        .a     (a),
        .b     (b),
        .done  (w_mul_done),
        .prod  (w_mul_prod)
    );

    // Single-cycle datapath result and carry
    always_comb begin
        w_alu_res   = w_add[W-1:0];
        w_alu_carry = 1'b0;
        case (op)
            OP_ADD: begin
                w_alu_res   = w_add[W-1:0];
                w_alu_carry = w_add[W];
            end
            OP_NOT: w_alu_res = ~a;
            OP_AND: w_alu_res = a & b;
            OP_SUB: begin
                w_alu_res   = a - b;
                w_alu_carry = (a < b);
            end
            OP_OR:  w_alu_res = a | b;
            OP_SHL: begin
                w_alu_res   = w_shl[W-1:0];
                w_alu_carry = w_shl[W];
            end
            OP_SHR: begin
                w_alu_res   = w_shr[W:1];
                w_alu_carry = w_shr[0];
            end
            default: begin
                w_alu_res   = w_add[W-1:0];
                w_alu_carry = 1'b0;
            end
        endcase
    end

    // Next-state and control: accept in IDLE, run MUL in BUSY, flush aborts and discards
    always_comb begin
        w_state_nx  = r_state;
        w_load      = 1'b0;
        w_res_nx    = w_alu_res;
        w_carry_nx  = w_alu_carry;
        w_mul_start = 1'b0;
        w_mul_clear = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (flush) begin
                    w_mul_clear = 1'b1;
                end else if (in_valid) begin
                    if (op == OP_MUL) begin
                        w_mul_start = 1'b1;
                        w_state_nx  = ST_BUSY;
                    end else begin
                        w_load = 1'b1;
                    end
                end
            end
            ST_BUSY: begin
                if (flush) begin
                    w_mul_clear = 1'b1;
                    w_state_nx  = ST_IDLE;
                end else if (w_mul_done) begin
                    w_load     = 1'b1;
                    w_res_nx   = w_mul_prod[W-1:0];
                    w_carry_nx = |w_mul_prod[2*W-1:W];
                    w_state_nx = ST_IDLE;
                end
            end
            default: w_state_nx = ST_IDLE;
        endcase
    end

    // State, handshake and result/flag registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_result    <= '0;
            r_carry     <= 1'b0;
            r_zero      <= 1'b0;
            r_neg       <= 1'b0;
        end else begin
            r_state     <= w_state_nx;
            r_in_ready  <= (w_state_nx == ST_IDLE);
            r_out_valid <= w_load;
            if (w_load) begin
                r_result <= w_res_nx;
                r_carry  <= w_carry_nx;
                r_zero   <= (w_res_nx == '0);
                r_neg    <= w_res_nx[W-1];
            end
        end
    end

endmodule

// File: tb/tb_alu_multicycle.sv
// Directed, table-driven bench for alu_multicycle (W=16) plus MUL, flush and reset sequences.
module tb_alu_multicycle;
    import alu_pkg::*;

    localparam int unsigned W = 16;

    typedef struct {
        string       name;
        logic [2:0]  op;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] res;
        logic        c;
        logic        z;
        logic        n;
    } vec_t;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         flush;
    logic         in_valid;
    logic         in_ready;
    logic [2:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         out_valid;
    logic [W-1:0] result;
    logic         carry;
    logic         zero;
    logic         neg;

    int n_cmp = 0;
    int n_bad = 0;

    vec_t vecs[12];

    alu_multicycle #(.W(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .result    (result),
        .carry     (carry),
        .zero      (zero),
        .neg       (neg)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%h expected=%h", name, got, exp);
        end
    endtask

    task automatic chk_out(input string name, input logic [15:0] r, input logic c,
                           input logic z, input logic n);
        chk({name, " result"}, 32'(result), 32'(r));
        chk({name, " carry"},  32'(carry),  32'(c));
        chk({name, " zero"},   32'(zero),   32'(z));
        chk({name, " neg"},    32'(neg),    32'(n));
    endtask

    task automatic drive(input logic v, input logic [2:0] o, input logic [15:0] x,
                         input logic [15:0] y);
        in_valid = v;
        op       = o;
        a        = x;
        b        = y;
    endtask

    initial begin
        int seen;

        vecs[0]  = '{"add_small",  OP_ADD, 16'h0001, 16'h0005, 16'h0006, 1'b0, 1'b0, 1'b0};
        vecs[1]  = '{"add_carry",  OP_ADD, 16'hFFFF, 16'hFFFB, 16'hFFFA, 1'b1, 1'b0, 1'b1};
        vecs[2]  = '{"sub_borrow", OP_SUB, 16'd20,   16'd30,   16'hFFF6, 1'b1, 1'b0, 1'b1};
        vecs[3]  = '{"sub_zero",   OP_SUB, 16'd5,    16'd5,    16'h0000, 1'b0, 1'b1, 1'b0};
        vecs[4]  = '{"shl_out",    OP_SHL, 16'h8001, 16'h0001, 16'h0002, 1'b1, 1'b0, 1'b0};
        vecs[5]  = '{"shr_zero",   OP_SHR, 16'h0001, 16'h0000, 16'h0001, 1'b0, 1'b0, 1'b0};
        vecs[6]  = '{"not",        OP_NOT, 16'h00FF, 16'h1234, 16'hFF00, 1'b0, 1'b0, 1'b1};
        vecs[7]  = '{"and",        OP_AND, 16'hF0F0, 16'h0FF0, 16'h00F0, 1'b0, 1'b0, 1'b0};
        vecs[8]  = '{"or",         OP_OR,  16'hF000, 16'h000F, 16'hF00F, 1'b0, 1'b0, 1'b1};
        vecs[9]  = '{"shr_two",    OP_SHR, 16'h8003, 16'h0002, 16'h2000, 1'b1, 1'b0, 1'b0};
        vecs[10] = '{"shl_hiamt",  OP_SHL, 16'h4000, 16'h0012, 16'h0000, 1'b1, 1'b1, 1'b0};
        vecs[11] = '{"add_wrap",   OP_ADD, 16'h8000, 16'h8000, 16'h0000, 1'b1, 1'b1, 1'b0};

        rst_n = 1'b0;
        flush = 1'b0;
        drive(1'b0, OP_ADD, '0, '0);

        // Reset state
        #12;
        chk("rst out_valid", 32'(out_valid), 32'd0);
        chk_out("rst", 16'h0000, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rst in_ready", 32'(in_ready), 32'd1);

        // Back-to-back single-cycle ops, one accepted per cycle
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            drive(1'b1, vecs[i].op, vecs[i].a, vecs[i].b);
            @(posedge clk);
            #1;
            chk({vecs[i].name, " out_valid"}, 32'(out_valid), 32'd1);
            chk({vecs[i].name, " in_ready"},  32'(in_ready),  32'd1);
            chk_out(vecs[i].name, vecs[i].res, vecs[i].c, vecs[i].z, vecs[i].n);
        end
        @(negedge clk);
        drive(1'b0, OP_ADD, '0, '0);
        @(posedge clk);
        #1;
        chk("idle out_valid", 32'(out_valid), 32'd0);
        chk_out("idle hold", 16'h0000, 1'b1, 1'b1, 1'b0);

        // MUL 300*300 with in_valid held throughout BUSY
        @(negedge clk);
        drive(1'b1, OP_MUL, 16'd300, 16'd300);
        @(posedge clk);
        #1;
        drive(1'b1, OP_ADD, 16'h0001, 16'h0001);
        for (int i = 1; i <= int'(W) + 1; i++) begin
            if (i > 1) begin
                @(posedge clk);
                #1;
            end
            if (i <= int'(W)) begin
                chk($sformatf("mul busy%0d in_ready", i), 32'(in_ready), 32'd0);
                chk($sformatf("mul busy%0d out_valid", i), 32'(out_valid), 32'd0);
            end else begin
                chk("mul done in_ready", 32'(in_ready), 32'd1);
                chk("mul done out_valid", 32'(out_valid), 32'd1);
                chk_out("mul300", 16'h5F90, 1'b1, 1'b0, 1'b0);
                drive(1'b0, OP_ADD, '0, '0);
            end
            if (i == 8) begin
                chk_out("mul busy hold", 16'h0000, 1'b1, 1'b1, 1'b0);
            end
        end
        @(posedge clk);
        #1;
        chk("mul single pulse", 32'(out_valid), 32'd0);

        // Flush 5 cycles into a MUL
        @(negedge clk);
        drive(1'b1, OP_MUL, 16'h1234, 16'h0002);
        @(posedge clk);
        #1;
        drive(1'b0, OP_ADD, '0, '0);
        repeat (4) @(posedge clk);
        @(negedge clk);
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        chk("flush in_ready", 32'(in_ready), 32'd1);
        chk("flush out_valid", 32'(out_valid), 32'd0);
        chk_out("flush hold", 16'h5F90, 1'b1, 1'b0, 1'b0);
        seen = 0;
        repeat (W + 2) begin
            @(posedge clk);
            #1;
            if (out_valid) seen++;
        end
        chk("flush no late out_valid", 32'(seen), 32'd0);

        // Flush in IDLE overrides a simultaneous in_valid
        @(negedge clk);
        flush = 1'b1;
        drive(1'b1, OP_ADD, 16'h0001, 16'h0001);
        @(posedge clk);
        #1;
        flush = 1'b0;
        drive(1'b0, OP_ADD, '0, '0);
        chk("idle flush out_valid", 32'(out_valid), 32'd0);
        chk("idle flush in_ready", 32'(in_ready), 32'd1);
        chk_out("idle flush hold", 16'h5F90, 1'b1, 1'b0, 1'b0);

        // MUL works again after a flush
        @(negedge clk);
        drive(1'b1, OP_MUL, 16'd3, 16'd5);
        @(posedge clk);
        #1;
        drive(1'b0, OP_ADD, '0, '0);
        seen = 0;
        for (int i = 0; i < 40 && seen == 0; i++) begin
            @(posedge clk);
            #1;
            if (out_valid) seen = i + 1;
        end
        chk("mul after flush latency", 32'(seen), 32'(W));
        chk_out("mul3x5", 16'h000F, 1'b0, 1'b0, 1'b0);

        // Asynchronous reset in the middle of a MUL
        @(negedge clk);
        drive(1'b1, OP_MUL, 16'd300, 16'd300);
        @(posedge clk);
        #1;
        drive(1'b0, OP_ADD, '0, '0);
        repeat (4) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("midrst out_valid", 32'(out_valid), 32'd0);
        chk_out("midrst", 16'h0000, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("midrst in_ready", 32'(in_ready), 32'd1);
        seen = 0;
        repeat (W + 2) begin
            @(posedge clk);
            #1;
            if (out_valid) seen++;
        end
        chk("midrst no stale out_valid", 32'(seen), 32'd0);

        // Unit usable after reset
        @(negedge clk);
        drive(1'b1, OP_SUB, 16'h0010, 16'h0001);
        @(posedge clk);
        #1;
        drive(1'b0, OP_ADD, '0, '0);
        chk("post rst out_valid", 32'(out_valid), 32'd1);
        chk_out("post rst sub", 16'h000F, 1'b0, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
